sha256_round_ctrl: RTL and testbench

Sequencing controller for the SHA-256 compression datapath. It accepts a one-cycle `start` from the 8-bit I/O wrapper and steps the datapath through initialisation, 64 rounds and the final digest addition. For each round it supplies the round index, the round constant K[t] and the message-word source select, then raises a one-cycle `hash_ready` when the digest is valid. The datapath itself holds the a..h, H0..H7 and W registers; this block holds only control state.

---
 rtl/sha256_pkg.sv | 40 ++++
 rtl/sha256_k_rom.sv | 13 +
 rtl/sha256_round_ctrl.sv | 109 ++++++++++
 tb/tb_sha256_round_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 compression control path.
// Holds the controller state encoding, the FIPS 180-4 round constants K[0..63],
// the initial hash value H0..H7 and the fixed round count.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int ROUNDS_C = 64;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_k_rom.sv
// Round-constant lookup: 6-bit round index to 32-bit K[t], purely combinational.
// Ports: addr (round index t), k (K[t]).
// No state; output follows addr in the same cycle.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  addr,
  output logic [31:0] k
);

  assign k = K_TABLE[addr];

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequencer for the SHA-256 compression datapath: INIT, 64 rounds, FINAL add, DONE.
// Ports: start/first_block request in; busy, init_state, iv_sel, round_en, round_idx,
//   w_sel, k_const, final_add, hash_ready control out. start->hash_ready is 67 cycles;
//   start outside IDLE/DONE is dropped, not queued.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_C
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        first_block,
  output logic        busy,
  output logic        init_state,
  output logic        iv_sel,
  output logic        round_en,
  output logic [5:0]  round_idx,
  output logic        w_sel,
  output logic [31:0] k_const,
  output logic        final_add,
  output logic        hash_ready
);

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t      state;
  logic [31:0] k_rom_out;

  sha256_k_rom u_k_rom (
    .addr (round_idx),
    .k    (k_rom_out)
  );

  // round_en is registered, so the gated constant still has no path from start.
  assign k_const = round_en ? k_rom_out : 32'h0;

  // All outputs are registered for the state being entered, so each output
  // lines up with the state it belongs to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      init_state <= 1'b0;
      iv_sel     <= 1'b0;
      round_en   <= 1'b0;
      round_idx  <= 6'd0;
      w_sel      <= 1'b0;
      final_add  <= 1'b0;
      hash_ready <= 1'b0;
    end else begin
      init_state <= 1'b0;
      final_add  <= 1'b0;
      hash_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= INIT;
            iv_sel     <= first_block;
            init_state <= 1'b1;
            busy       <= 1'b1;
          end
        end
        INIT: begin
          state     <= ROUND;
          round_en  <= 1'b1;
          round_idx <= 6'd0;
          w_sel     <= 1'b1;
        end
        ROUND: begin
          if (round_idx == LAST_T) begin
            state     <= FINAL;
            round_en  <= 1'b0;
            round_idx <= 6'd0;
            w_sel     <= 1'b0;
            final_add <= 1'b1;
          end else begin
            round_idx <= round_idx + 6'd1;
            // Next round still takes a message word while t+1 < 16.
            w_sel     <= (round_idx < 6'd15);
          end
        end
        FINAL: begin
          state      <= DONE;
          hash_ready <= 1'b1;
          busy       <= 1'b0;
        end
        DONE: begin
          if (start) begin
            state      <= INIT;
            iv_sel     <= first_block;
            init_state <= 1'b1;
            busy       <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          round_en  <= 1'b0;
          round_idx <= 6'd0;
          w_sel     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
module tb_sha256_round_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        first_block = 1'b0;
  logic        busy, init_state, iv_sel, round_en, w_sel, final_add, hash_ready;
  logic [5:0]  round_idx;
  logic [31:0] k_const;

  sha256_round_ctrl #(.ROUNDS(64)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .first_block (first_block),
    .busy        (busy),
    .init_state  (init_state),
    .iv_sel      (iv_sel),
    .round_en    (round_en),
    .round_idx   (round_idx),
    .w_sel       (w_sel),
    .k_const     (k_const),
    .final_add   (final_add),
    .hash_ready  (hash_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;
  int ren_cnt, fa_cnt, fa_cyc, hr_cnt, hr_first, hr_cyc, init_cnt, init_first, init_cyc;
  logic iv_first, iv_last;
  logic [31:0] k_log [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    ren_cnt = 0; fa_cnt = 0; fa_cyc = -1; hr_cnt = 0; hr_first = -1; hr_cyc = -1;
    init_cnt = 0; init_first = -1; init_cyc = -1; iv_first = 1'bx; iv_last = 1'bx;
    for (int i = 0; i < 64; i++) k_log[i] = 32'hdeadbeef;
  endtask

  // Step until cycle c_end, pulsing start in cycles s0/s1/s2 with first_block fbv[n].
  // Cycle n is observed at the falling edge after the n-th rising edge.
  task automatic watch(input int c_end, input int s0, input int s1, input int s2,
                       input logic [2:0] fbv);
    int t;
    while (cyc < c_end) begin
      start       = (cyc == s0) || (cyc == s1) || (cyc == s2);
      first_block = (cyc == s1) ? fbv[1] : (cyc == s2) ? fbv[2] : fbv[0];
      @(posedge clk);
      @(negedge clk);
      cyc++;
      start = 1'b0;
      chk("strobe_excl", 32'($countones({init_state, round_en, final_add, hash_ready}) <= 1), 1);
      chk("busy", busy, init_state | round_en | final_add);
      if (init_state) begin
        init_cnt++;
        if (init_cnt == 1) begin
          init_first = cyc;
          iv_first   = iv_sel;
        end
        init_cyc = cyc;
        iv_last  = iv_sel;
        chk("init_idx", round_idx, 0);
      end
      if (round_en) begin
        ren_cnt++;
        t = cyc - init_cyc - 1;
        chk("round_idx", round_idx, 32'(t));
        chk("w_sel", w_sel, (t < 16) ? 1 : 0);
        if (t >= 0 && t < 64) k_log[t] = k_const;
      end else begin
        chk("idle_idx", round_idx, 0);
        chk("idle_k", k_const, 0);
        chk("idle_wsel", w_sel, 0);
      end
      if (final_add) begin
        fa_cnt++;
        fa_cyc = cyc;
      end
      if (hash_ready) begin
        hr_cnt++;
        if (hr_cnt == 1) hr_first = cyc;
        hr_cyc = cyc;
      end
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ctrl", {busy, init_state, iv_sel, round_en, round_idx, w_sel, final_add, hash_ready}, 0);
    chk("rst_k", k_const, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Idle for 10 cycles
    cyc = 0; clear_stats();
    watch(10, -1, -1, -1, 3'b000);
    chk("idle_init_cnt", init_cnt, 0);
    chk("idle_hr_cnt", hr_cnt, 0);
    chk("idle_iv_sel", iv_sel, 0);

    // Single block from the IV
    cyc = 0; clear_stats();
    watch(70, 0, -1, -1, 3'b001);
    chk("t1_init_cyc", init_first, 1);
    chk("t1_iv_sel", iv_first, 1);
    chk("t1_round_cnt", ren_cnt, 64);
    chk("t1_k0", k_log[0], 32'h428a2f98);
    chk("t1_k4", k_log[4], 32'h3956c25b);
    chk("t1_k6", k_log[6], 32'h923f82a4);
    chk("t1_k15", k_log[15], 32'hc19bf174);
    chk("t1_k16", k_log[16], 32'he49b69c1);
    chk("t1_k63", k_log[63], 32'hc67178f2);
    chk("t1_fa_cnt", fa_cnt, 1);
    chk("t1_fa_cyc", fa_cyc, 66);
    chk("t1_hr_cnt", hr_cnt, 1);
    chk("t1_hr_cyc", hr_cyc, 67);

    // Starts during INIT..FINAL are dropped
    cyc = 0; clear_stats();
    watch(75, 0, 5, 66, 3'b000);
    chk("ign_init_cnt", init_cnt, 1);
    chk("ign_iv_sel", iv_first, 0);
    chk("ign_hr_cnt", hr_cnt, 1);
    chk("ign_hr_cyc", hr_cyc, 67);

    // Back-to-back: second start in the DONE cycle, chaining from the digest
    cyc = 0; clear_stats();
    watch(140, 0, 67, -1, 3'b001);
    chk("b2b_init_cnt", init_cnt, 2);
    chk("b2b_iv_first", iv_first, 1);
    chk("b2b_init2_cyc", init_cyc, 68);
    chk("b2b_iv_last", iv_last, 0);
    chk("b2b_round_cnt", ren_cnt, 128);
    chk("b2b_hr_cnt", hr_cnt, 2);
    chk("b2b_hr_first", hr_first, 67);
    chk("b2b_hr_second", hr_cyc, 134);

    // Reset in the middle of the rounds
    cyc = 0; clear_stats();
    watch(32, 0, -1, -1, 3'b001);
    chk("mid_round_idx", round_idx, 30);
    chk("mid_round_en", round_en, 1);
    rstn = 1'b0;
    #1;
    chk("arst_ctrl", {busy, init_state, iv_sel, round_en, round_idx, w_sel, final_add, hash_ready}, 0);
    chk("arst_k", k_const, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cyc = 0; clear_stats();
    watch(70, -1, -1, -1, 3'b000);
    chk("post_rst_hr_cnt", hr_cnt, 0);
    chk("post_rst_init_cnt", init_cnt, 0);
    cyc = 0; clear_stats();
    watch(70, 0, -1, -1, 3'b000);
    chk("rerun_init_cyc", init_first, 1);
    chk("rerun_iv_sel", iv_first, 0);
    chk("rerun_round_cnt", ren_cnt, 64);
    chk("rerun_fa_cyc", fa_cyc, 66);
    chk("rerun_hr_cnt", hr_cnt, 1);
    chk("rerun_hr_cyc", hr_cyc, 67);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
